// File: rtl/ex_mem_reg_if.sv
// EX -> MEM stage bundle: EX inputs, MEM-side outputs, redirect and perf counters.
// slave = pipeline register view, master = surrounding pipeline view.
interface ex_mem_reg_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned RegW = 5;
  localparam int unsigned F3W  = 3;
  localparam int unsigned CntW = 32;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_alu_result;
  logic            ex_branch;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [XLEN-1:0] ex_store_data;
  logic [RegW-1:0] ex_rd;
  logic            ex_reg_we;
  logic            ex_mem_re;
  logic            ex_mem_we;
  logic [F3W-1:0]  ex_funct3;
  logic            mem_stall;
  logic            flush;

  logic            mem_valid;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_store_data;
  logic [RegW-1:0] mem_rd;
  logic            mem_reg_we;
  logic            mem_mem_re;
  logic            mem_mem_we;
  logic [F3W-1:0]  mem_funct3;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [CntW-1:0] perf_branch_cnt;
  logic [CntW-1:0] perf_taken_cnt;

  modport slave (
    input  ex_valid, ex_pc, ex_imm, ex_alu_result, ex_branch,
           ex_is_branch, ex_is_jal, ex_is_jalr, ex_store_data, ex_rd,
           ex_reg_we, ex_mem_re, ex_mem_we, ex_funct3, mem_stall, flush,
    output ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_we, mem_mem_re, mem_mem_we, mem_funct3,
           redirect_valid, redirect_pc, perf_branch_cnt, perf_taken_cnt
  );

  modport master (
    output ex_valid, ex_pc, ex_imm, ex_alu_result, ex_branch,
           ex_is_branch, ex_is_jal, ex_is_jalr, ex_store_data, ex_rd,
           ex_reg_we, ex_mem_re, ex_mem_we, ex_funct3, mem_stall, flush,
    input  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_we, mem_mem_re, mem_mem_we, mem_funct3,
           redirect_valid, redirect_pc, perf_branch_cnt, perf_taken_cnt
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch/jump resolution, one-cycle redirect and wrong-path squash.
// Optional branch performance counters enabled by defining EXMEM_PERF_CNT_EN.
module ex_mem_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_mem_reg_if.slave  bus
);
  localparam int unsigned RegW = 5;
  localparam int unsigned F3W  = 3;

  logic            ready;
  logic            capture;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] result;

  logic            mem_valid_q,  mem_valid_d;
  logic [XLEN-1:0] alu_q,        alu_d;
  logic [XLEN-1:0] sd_q,         sd_d;
  logic [RegW-1:0] rd_q,         rd_d;
  logic            reg_we_q,     reg_we_d;
  logic            mem_re_q,     mem_re_d;
  logic            mem_we_q,     mem_we_d;
  logic [F3W-1:0]  f3_q,         f3_d;
  logic            redir_vld_q,  redir_vld_d;
  logic [XLEN-1:0] redir_pc_q,   redir_pc_d;

  // Ready depends only on the MEM side, never on ex_valid.
  assign ready = !(mem_valid_q && bus.mem_stall);

  // The cycle after a redirect (or any flush) carries a wrong-path instruction.
  always_comb begin
    capture = bus.ex_valid && ready && !(redir_vld_q || bus.flush);
    taken   = (bus.ex_is_branch && bus.ex_branch) || bus.ex_is_jal || bus.ex_is_jalr;
    target  = bus.ex_is_jalr ? {bus.ex_alu_result[XLEN-1:1], 1'b0}
                             : bus.ex_pc + bus.ex_imm;
    result  = (bus.ex_is_jal || bus.ex_is_jalr) ? bus.ex_pc + XLEN'(4)
                                                : bus.ex_alu_result;
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    alu_d       = alu_q;
    sd_d        = sd_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    f3_d        = f3_q;
    redir_vld_d = 1'b0;
    redir_pc_d  = redir_pc_q;

    if (bus.flush) begin
      mem_valid_d = 1'b0;
    end else if (capture) begin
      mem_valid_d = 1'b1;
      alu_d       = result;
      sd_d        = bus.ex_store_data;
      rd_d        = bus.ex_rd;
      reg_we_d    = bus.ex_reg_we;
      mem_re_d    = bus.ex_mem_re;
      mem_we_d    = bus.ex_mem_we;
      f3_d        = bus.ex_funct3;
      if (taken) begin
        redir_vld_d = 1'b1;
        redir_pc_d  = target;
      end
    end else if (mem_valid_q && !bus.mem_stall) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      alu_q       <= '0;
      sd_q        <= '0;
      rd_q        <= '0;
      reg_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      f3_q        <= '0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      alu_q       <= alu_d;
      sd_q        <= sd_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      f3_q        <= f3_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

`ifdef EXMEM_PERF_CNT_EN
  localparam int unsigned CntW = 32;
  logic [CntW-1:0] br_cnt_q, br_cnt_d;
  logic [CntW-1:0] tk_cnt_q, tk_cnt_d;

  // Counts only non-squashed conditional branches; flush does not clear them.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (capture && bus.ex_is_branch) begin
      br_cnt_d = br_cnt_q + CntW'(1);
      if (bus.ex_branch) tk_cnt_d = tk_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign bus.perf_branch_cnt = br_cnt_q;
  assign bus.perf_taken_cnt  = tk_cnt_q;
`else
  assign bus.perf_branch_cnt = '0;
  assign bus.perf_taken_cnt  = '0;
`endif

  assign bus.ex_ready       = ready;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_alu_result = alu_q;
  assign bus.mem_store_data = sd_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_reg_we     = reg_we_q;
  assign bus.mem_mem_re     = mem_re_q;
  assign bus.mem_mem_we     = mem_we_q;
  assign bus.mem_funct3     = f3_q;
  assign bus.redirect_valid = redir_vld_q;
  assign bus.redirect_pc    = redir_pc_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vector table, reset/stall sequences, random run against a reference model.
module tb_ex_mem_reg;
  localparam bit PerfEn =
`ifdef EXMEM_PERF_CNT_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, alu, sd;
    logic        br, is_br, is_jal, is_jalr;
    logic [4:0]  rd;
    logic        we, re, mwe;
    logic [2:0]  f3;
    logic        stall, flush;
  } in_t;

  typedef struct {
    in_t         in;
    logic        rdy;
    logic        mv, rv;
    logic [31:0] rpc, alu;
    logic        we;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  ex_mem_reg_if #(.XLEN(32)) bus ();
  ex_mem_reg #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic in_t mk(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] alu, input logic br, input int kind,
                             input logic [4:0] rd, input logic we, input logic stall,
                             input logic flush);
    in_t r;
    r.valid = v;  r.pc = pc;  r.imm = imm;  r.alu = alu;  r.sd = alu ^ 32'h1234_5678;
    r.br = br;  r.is_br = (kind == 1);  r.is_jal = (kind == 2);  r.is_jalr = (kind == 3);
    r.rd = rd;  r.we = we;  r.re = 1'b0;  r.mwe = 1'b0;  r.f3 = 3'd2;
    r.stall = stall;  r.flush = flush;
    return r;
  endfunction

  task automatic drive(input in_t v);
    bus.ex_valid = v.valid;  bus.ex_pc = v.pc;  bus.ex_imm = v.imm;
    bus.ex_alu_result = v.alu;  bus.ex_store_data = v.sd;  bus.ex_branch = v.br;
    bus.ex_is_branch = v.is_br;  bus.ex_is_jal = v.is_jal;  bus.ex_is_jalr = v.is_jalr;
    bus.ex_rd = v.rd;  bus.ex_reg_we = v.we;  bus.ex_mem_re = v.re;  bus.ex_mem_we = v.mwe;
    bus.ex_funct3 = v.f3;  bus.mem_stall = v.stall;  bus.flush = v.flush;
  endtask

  // Reference model state: what MEM holds, the pending redirect and the counters.
  logic        m_valid, r_valid;
  logic [31:0] m_alu, m_sd, r_pc, c_br, c_tk;
  logic [4:0]  m_rd;
  logic        m_we, m_re, m_mwe;
  logic [2:0]  m_f3;

  task automatic model_reset();
    m_valid = 0; r_valid = 0; m_alu = 0; m_sd = 0; r_pc = 0; c_br = 0; c_tk = 0;
    m_rd = 0; m_we = 0; m_re = 0; m_mwe = 0; m_f3 = 0;
  endtask

  task automatic model_edge(input in_t v);
    bit stage_free, wrong_path, kept, jumps;
    stage_free = !(m_valid && v.stall);
    wrong_path = r_valid || v.flush;
    kept       = v.valid && stage_free && !wrong_path;
    jumps      = kept && ((v.is_br && v.br) || v.is_jal || v.is_jalr);
    r_valid = jumps;
    if (jumps) r_pc = v.is_jalr ? (v.alu & 32'hFFFF_FFFE) : v.pc + v.imm;
    if (kept) begin
      m_valid = 1;
      m_alu = (v.is_jal || v.is_jalr) ? v.pc + 32'd4 : v.alu;
      m_sd = v.sd; m_rd = v.rd; m_we = v.we; m_re = v.re; m_mwe = v.mwe; m_f3 = v.f3;
      if (v.is_br) begin
        c_br = c_br + 1;
        if (v.br) c_tk = c_tk + 1;
      end
    end else if (v.flush || !v.stall) begin
      m_valid = 0;
    end
  endtask

  rec_t vecs[16];

  initial begin
    in_t v;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst_mem_valid", 32'(bus.mem_valid), 0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_ex_ready", 32'(bus.ex_ready), 1);
    chk("rst_perf_branch", bus.perf_branch_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //            v  pc        imm       alu       br kind rd we st fl     rdy mv rv rpc        alu       we
    vecs[0]  = '{mk(1, 32'h100, 32'h20,  32'h0,    1, 1, 0, 0, 0, 0), 1, 1, 1, 32'h120,  32'h0,   0};
    vecs[1]  = '{mk(1, 32'h104, 32'h0,   32'h77,   0, 0, 5, 1, 0, 0), 1, 0, 0, 32'h120,  32'h0,   0};
    vecs[2]  = '{mk(0, 32'h0,   32'h0,   32'h0,    0, 0, 0, 0, 0, 0), 1, 0, 0, 32'h120,  32'h0,   0};
    vecs[3]  = '{mk(1, 32'h400, 32'h0,   32'h2003, 0, 3, 1, 1, 0, 0), 1, 1, 1, 32'h2002, 32'h404, 1};
    vecs[4]  = '{mk(0, 32'h0,   32'h0,   32'h0,    0, 0, 0, 0, 0, 0), 1, 0, 0, 32'h2002, 32'h404, 1};
    vecs[5]  = '{mk(1, 32'h200, 32'h40,  32'h0,    0, 1, 0, 0, 0, 0), 1, 1, 0, 32'h2002, 32'h0,   0};
    vecs[6]  = '{mk(1, 32'h300, 32'h0,   32'h55,   0, 0, 3, 1, 0, 0), 1, 1, 0, 32'h2002, 32'h55,  1};
    vecs[7]  = '{mk(1, 32'h304, 32'h0,   32'h66,   0, 0, 4, 1, 1, 0), 0, 1, 0, 32'h2002, 32'h55,  1};
    vecs[8]  = '{mk(1, 32'h304, 32'h0,   32'h66,   0, 0, 4, 1, 1, 0), 0, 1, 0, 32'h2002, 32'h55,  1};
    vecs[9]  = '{mk(1, 32'h304, 32'h0,   32'h66,   0, 0, 4, 1, 1, 0), 0, 1, 0, 32'h2002, 32'h55,  1};
    vecs[10] = '{mk(1, 32'h304, 32'h0,   32'h66,   0, 0, 4, 1, 0, 0), 1, 1, 0, 32'h2002, 32'h66,  1};
    vecs[11] = '{mk(1, 32'h500, 32'h100, 32'h0,    0, 2, 1, 1, 0, 1), 1, 0, 0, 32'h2002, 32'h66,  1};
    vecs[12] = '{mk(1, 32'h600, 32'h10,  32'h0,    0, 2, 1, 1, 0, 0), 1, 1, 1, 32'h610,  32'h604, 1};
    vecs[13] = '{mk(1, 32'h608, 32'h0,   32'h99,   0, 0, 2, 1, 1, 0), 0, 1, 0, 32'h610,  32'h604, 1};
    vecs[14] = '{mk(0, 32'h0,   32'h0,   32'h0,    0, 0, 0, 0, 1, 1), 0, 0, 0, 32'h610,  32'h604, 1};
    vecs[15] = '{mk(0, 32'h0,   32'h0,   32'h0,    0, 0, 0, 0, 0, 0), 1, 0, 0, 32'h610,  32'h604, 1};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].in);
      #1;
      chk($sformatf("v%0d_ex_ready", i), 32'(bus.ex_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_valid), 32'(vecs[i].mv));
      chk($sformatf("v%0d_redirect_valid", i), 32'(bus.redirect_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].rpc);
      chk($sformatf("v%0d_mem_alu_result", i), bus.mem_alu_result, vecs[i].alu);
      chk($sformatf("v%0d_mem_reg_we", i), 32'(bus.mem_reg_we), 32'(vecs[i].we));
    end
    chk("tbl_perf_branch", bus.perf_branch_cnt, PerfEn ? 32'd2 : 32'd0);
    chk("tbl_perf_taken", bus.perf_taken_cnt, PerfEn ? 32'd1 : 32'd0);

    // Asynchronous reset in the middle of a redirect while MEM is stalled.
    drive(mk(1, 32'h700, 32'h8, 32'h0, 1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("seq_redirect_valid", 32'(bus.redirect_valid), 1);
    chk("seq_redirect_pc", bus.redirect_pc, 32'h708);
    drive(mk(1, 32'h704, 32'h0, 32'h11, 0, 0, 1, 1, 1, 0));
    #1;
    chk("seq_stall_ready", 32'(bus.ex_ready), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("seq_rst_redirect_valid", 32'(bus.redirect_valid), 0);
    chk("seq_rst_mem_valid", 32'(bus.mem_valid), 0);
    chk("seq_rst_redirect_pc", bus.redirect_pc, 0);
    chk("seq_rst_perf_branch", bus.perf_branch_cnt, 0);
    chk("seq_rst_perf_taken", bus.perf_taken_cnt, 0);
    chk("seq_rst_ex_ready", 32'(bus.ex_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 32'h800, 32'h0, 32'hABC, 0, 0, 7, 1, 0, 0));
    @(posedge clk);
    #1;
    chk("seq_first_capture_valid", 32'(bus.mem_valid), 1);
    chk("seq_first_capture_alu", bus.mem_alu_result, 32'hABC);

    // Random run against the reference model from a fresh reset.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      v.valid = ($urandom_range(0, 9) < 7);
      v.pc = $urandom;  v.imm = $urandom;  v.alu = $urandom;  v.sd = $urandom;
      v.br = 1'($urandom_range(0, 1));
      begin
        int k = $urandom_range(0, 3);
        v.is_br = (k == 1);  v.is_jal = (k == 2);  v.is_jalr = (k == 3);
      end
      v.rd = 5'($urandom);  v.we = 1'($urandom);  v.re = 1'($urandom);  v.mwe = 1'($urandom);
      v.f3 = 3'($urandom);
      v.stall = ($urandom_range(0, 9) < 3);
      v.flush = ($urandom_range(0, 19) == 0);
      drive(v);
      #1;
      chk("rnd_ex_ready", 32'(bus.ex_ready), 32'(!(m_valid && v.stall)));
      model_edge(v);
      @(posedge clk);
      #1;
      chk("rnd_mem_valid", 32'(bus.mem_valid), 32'(m_valid));
      chk("rnd_mem_alu_result", bus.mem_alu_result, m_alu);
      chk("rnd_mem_store_data", bus.mem_store_data, m_sd);
      chk("rnd_mem_rd", 32'(bus.mem_rd), 32'(m_rd));
      chk("rnd_mem_ctl", {29'd0, bus.mem_reg_we, bus.mem_mem_re, bus.mem_mem_we},
          {29'd0, m_we, m_re, m_mwe});
      chk("rnd_mem_funct3", 32'(bus.mem_funct3), 32'(m_f3));
      chk("rnd_redirect_valid", 32'(bus.redirect_valid), 32'(r_valid));
      chk("rnd_redirect_pc", bus.redirect_pc, r_pc);
      chk("rnd_perf_branch", bus.perf_branch_cnt, PerfEn ? c_br : 32'd0);
      chk("rnd_perf_taken", bus.perf_taken_cnt, PerfEn ? c_tk : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline stage of the RV32 core, directly downstream of the ALU. Each cycle it consumes the ALU result and branch flag together with the EX-stage control bundle. It registers them for the memory stage and resolves control flow: it computes branch and jump targets, produces a one-cycle PC redirect, and squashes the wrong-path instruction behind a taken branch. It owns the valid/ready handshake between EX and MEM, including stall hold and flush.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_ready  out  1  stage accepts EX this cycle; equals !(mem_valid && mem_stall).
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_alu_result  in  XLEN  ALU result; for JALR this is rs1+imm.
- ex_branch  in  1  ALU branch-condition flag.
- ex_is_branch, ex_is_jal, ex_is_jalr  in  1 each  instruction class; mutually exclusive.
- ex_store_data  in  XLEN  forwarded rs2 value.
- ex_rd  in  5  destination register.
- ex_reg_we, ex_mem_re, ex_mem_we  in  1 each  write-back, load and store enables.
- ex_funct3  in  3  memory access size/sign.
- mem_stall  in  1  MEM cannot accept a new instruction.
- flush  in  1  trap/pipeline flush.
- mem_valid  out  1  MEM-side bundle is valid.
- mem_alu_result, mem_store_data  out  XLEN each  registered result and store data.
- mem_rd  out  5; mem_reg_we, mem_mem_re, mem_mem_we  out  1 each; mem_funct3  out  3.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- perf_branch_cnt, perf_taken_cnt  out  32 each  performance counters; see Configuration.

## Operation
- Accept condition: accept = ex_valid && ex_ready.
- Squash condition: squash = redirect_valid || flush. An accepted instruction under squash is consumed and discarded. mem_valid is not set, and no redirect or counter update results.
- Capture: on accept && !squash, load all mem_* fields and set mem_valid=1.
- Link value: for ex_is_jal or ex_is_jalr, mem_alu_result = ex_pc+4, not the ALU result.
- Drain: when mem_valid && !mem_stall and no capture occurs, mem_valid clears to 0. Data fields hold their last value.
- Stall: when mem_valid && mem_stall, all mem_* outputs hold and ex_ready=0.
- Taken condition: taken = (ex_is_branch && ex_branch) || ex_is_jal || ex_is_jalr, evaluated on a non-squashed capture.
- Targets:
  - Branch and JAL: ex_pc+ex_imm.
  - JALR: ex_alu_result with bit 0 cleared.
  - All sums are XLEN-bit modulo; wrap-around is ignored.
- Redirect: on a taken capture, redirect_valid=1 and redirect_pc=target in the next cycle. Otherwise redirect_valid=0.
- Flush:
  - Clears mem_valid and redirect_valid at the next edge.
  - Flush has priority over a simultaneous capture and over a stall.
  - redirect_pc holds its value.
- Squash rationale: the instruction arriving in the redirect cycle is the wrong-path successor and is dropped.
- Not-taken branch: captured normally, with no redirect.

## Timing
- Latency: EX inputs appear on mem_* one cycle after accept. Redirect appears in the same cycle as the captured instruction's mem_valid.
- Pulse width: redirect_valid is high for exactly one cycle, even if MEM stalls in that cycle.
- ex_ready is combinational from mem_valid and mem_stall only; it has no path from ex_valid.
- Reset: asynchronous assert sets every output register to 0 (mem_*, mem_valid, redirect_valid, redirect_pc, counters), so ex_ready=1. Reset mid-stall or mid-redirect discards the in-flight instruction. Release is synchronous-safe; the first capture occurs at the first edge after rst_n rises.

## Configuration
- EXMEM_PERF_CNT_EN defined:
  - perf_branch_cnt increments on every non-squashed captured conditional branch.
  - perf_taken_cnt increments on every taken one.
  - Both are 32-bit, wrap at 0xFFFFFFFF→0, are cleared by reset, and are unaffected by flush.
- EXMEM_PERF_CNT_EN undefined: no counter logic; both ports are tied to 0.

## Test plan
- Taken BEQ: pc=0x100, imm=0x20, ex_branch=1 → next cycle redirect_valid=1, redirect_pc=0x120. Instruction presented in that cycle is dropped; mem_valid=0 the cycle after.
- JALR: pc=0x400, alu_result=0x2003, rd=1 → redirect_pc=0x2002, mem_alu_result=0x404, mem_reg_we=1.
- Not-taken BNE: ex_branch=0 → mem_valid=1, redirect_valid=0. With EXMEM_PERF_CNT_EN, branch_cnt=1 and taken_cnt=0.
- Stall: capture ADD result 0x55, hold mem_stall=1 for 3 cycles while ex_valid=1 → ex_ready=0 and mem_alu_result=0x55 throughout. Release → next instruction captured one cycle later.
- Flush together with a taken-JAL capture → mem_valid=0 and redirect_valid=0 next cycle.
- Reset: assert rst_n=0 mid-redirect → redirect_valid, mem_valid and counters read 0 immediately, without waiting for a clock edge.
